// File: rtl/stack_pkg.sv
// Shared definitions for the LIFO stack controller: operation encoding
// and the controller FSM state type.
package stack_pkg;

  // Operation code is {op_push, op_pop}
  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_POP  = 2'b01;
  localparam logic [1:0] OP_PUSH = 2'b10;
  localparam logic [1:0] OP_REPL = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    RESP = 2'd2
  } st_e;

  // Pack the two request strobes into an operation code
  function automatic logic [1:0] op_code(input logic push, input logic pop);
    return {push, pop};
  endfunction

endpackage

// File: rtl/stack_ram.sv
// Single-port synchronous RAM for the stack storage. The read is registered
// and returns the old contents when a write hits the same address in the
// same cycle, which is what the replace operation relies on.
module stack_ram
  import stack_pkg::*;
#(
  parameter  int WIDTH = 24,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic             re,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port plus read-before-write registered read on the shared address
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/stack_mem_ctrl.sv
// LIFO stack controller: accepts push / pop / replace requests on a
// valid/ready port, keeps the entry count and full/empty flags, records
// sticky overflow/underflow errors and returns popped words through a
// valid/ready response register. Storage lives in stack_ram.
module stack_mem_ctrl
  import stack_pkg::*;
#(
  parameter  int WIDTH = 24,
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic             op_push,
  input  logic             op_pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [WIDTH-1:0] rd_data,
  output logic [PTR_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             err_ovf,
  output logic             err_unf,
  input  logic             err_clr
);

  localparam int AW = $clog2(DEPTH);

  st_e              state_reg, state_next;
  logic [PTR_W-1:0] count_reg, count_next;
  logic             full_reg, empty_reg;
  logic             rd_valid_reg, rd_valid_next;
  logic [WIDTH-1:0] rd_data_reg, rd_data_next;
  logic             err_ovf_reg, err_ovf_next;
  logic             err_unf_reg, err_unf_next;

  logic             ovf_set, unf_set;
  logic             ram_we, ram_re;
  logic [AW-1:0]    ram_addr;
  logic [AW-1:0]    top_idx;
  logic [WIDTH-1:0] ram_rdata;

  // Index of the current top entry; only meaningful when not empty
  assign top_idx = AW'(count_reg - PTR_W'(1));

  stack_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (wr_data),
    .rdata (ram_rdata)
  );

  // Next-state, pointer, RAM control and error-set decode
  always_comb begin
    state_next    = state_reg;
    count_next    = count_reg;
    rd_valid_next = rd_valid_reg;
    rd_data_next  = rd_data_reg;
    ovf_set       = 1'b0;
    unf_set       = 1'b0;
    ram_we        = 1'b0;
    ram_re        = 1'b0;
    ram_addr      = top_idx;
    op_ready      = 1'b0;

    case (state_reg)
      IDLE: begin
        op_ready = 1'b1;
        if (op_valid) begin
          case (op_code(op_push, op_pop))
            OP_PUSH: begin
              if (full_reg) begin
                ovf_set = 1'b1;
              end else begin
                ram_we     = 1'b1;
                ram_addr   = count_reg[AW-1:0];
                count_next = count_reg + PTR_W'(1);
              end
            end
            OP_POP: begin
              if (empty_reg) begin
                unf_set = 1'b1;
              end else begin
                ram_re     = 1'b1;
                count_next = count_reg - PTR_W'(1);
                state_next = READ;
              end
            end
            OP_REPL: begin
              // Old top is read out while the new word overwrites it
              if (empty_reg) begin
                unf_set = 1'b1;
              end else begin
                ram_re     = 1'b1;
                ram_we     = 1'b1;
                state_next = READ;
              end
            end
            default: ;
          endcase
        end
      end
      READ: begin
        rd_data_next  = ram_rdata;
        rd_valid_next = 1'b1;
        state_next    = RESP;
      end
      RESP: begin
        if (rd_ready) begin
          rd_valid_next = 1'b0;
          state_next    = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // A new error on the same edge as a clear keeps the flag set
    err_ovf_next = ovf_set | (err_ovf_reg & ~err_clr);
    err_unf_next = unf_set | (err_unf_reg & ~err_clr);
  end

  // State, pointer, flags and response registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      count_reg    <= '0;
      full_reg     <= 1'b0;
      empty_reg    <= 1'b1;
      rd_valid_reg <= 1'b0;
      rd_data_reg  <= '0;
      err_ovf_reg  <= 1'b0;
      err_unf_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      full_reg     <= (count_next == PTR_W'(DEPTH));
      empty_reg    <= (count_next == '0);
      rd_valid_reg <= rd_valid_next;
      rd_data_reg  <= rd_data_next;
      err_ovf_reg  <= err_ovf_next;
      err_unf_reg  <= err_unf_next;
    end
  end

  assign rd_valid = rd_valid_reg;
  assign rd_data  = rd_data_reg;
  assign count    = count_reg;
  assign full     = full_reg;
  assign empty    = empty_reg;
  assign err_ovf  = err_ovf_reg;
  assign err_unf  = err_unf_reg;

endmodule

// File: tb/tb_stack_mem_ctrl.sv
// Bench for stack_mem_ctrl: a 24x8 and an 8x2 instance driven by directed
// and random operations. A plain array-stack model predicts every popped
// word into a per-instance queue; a monitor compares responses on its own.
module tb_stack_mem_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        op_valid [2];
  logic        op_push  [2];
  logic        op_pop   [2];
  logic        rd_ready [2];
  logic        err_clr  [2];
  logic [23:0] wr_data  [2];
  logic        op_ready [2];
  logic        rd_valid [2];
  logic        full     [2];
  logic        empty    [2];
  logic        err_ovf  [2];
  logic        err_unf  [2];
  logic [23:0] rd_data  [2];
  logic [31:0] cnt      [2];

  logic [3:0]  count_a;
  logic [1:0]  count_b;
  logic [7:0]  rd_data_b;

  assign cnt[0]     = {28'h0, count_a};
  assign cnt[1]     = {30'h0, count_b};
  assign rd_data[1] = {16'h0, rd_data_b};

  stack_mem_ctrl #(.WIDTH(24), .DEPTH(8)) u_dut_a (
    .clk      (clk),
    .reset    (reset),
    .op_valid (op_valid[0]),
    .op_ready (op_ready[0]),
    .op_push  (op_push[0]),
    .op_pop   (op_pop[0]),
    .wr_data  (wr_data[0]),
    .rd_valid (rd_valid[0]),
    .rd_ready (rd_ready[0]),
    .rd_data  (rd_data[0]),
    .count    (count_a),
    .full     (full[0]),
    .empty    (empty[0]),
    .err_ovf  (err_ovf[0]),
    .err_unf  (err_unf[0]),
    .err_clr  (err_clr[0])
  );

  stack_mem_ctrl #(.WIDTH(8), .DEPTH(2)) u_dut_b (
    .clk      (clk),
    .reset    (reset),
    .op_valid (op_valid[1]),
    .op_ready (op_ready[1]),
    .op_push  (op_push[1]),
    .op_pop   (op_pop[1]),
    .wr_data  (wr_data[1][7:0]),
    .rd_valid (rd_valid[1]),
    .rd_ready (rd_ready[1]),
    .rd_data  (rd_data_b),
    .count    (count_b),
    .full     (full[1]),
    .empty    (empty[1]),
    .err_ovf  (err_ovf[1]),
    .err_unf  (err_unf[1]),
    .err_clr  (err_clr[1])
  );

  // Reference model: plain array stacks with a size, plus error flags
  logic [23:0] mdl [2][8];
  int          msz [2];
  bit          m_ovf [2];
  bit          m_unf [2];
  logic [23:0] exp0_q [$];
  logic [23:0] exp1_q [$];

  int errors = 0;
  int checks = 0;

  function automatic int dep(int i);
    return (i == 0) ? 8 : 2;
  endfunction

  function automatic logic [23:0] msk(int i);
    return (i == 0) ? 24'hFFFFFF : 24'h0000FF;
  endfunction

  function automatic int q_size(int i);
    return (i == 0) ? exp0_q.size() : exp1_q.size();
  endfunction

  function automatic logic [23:0] q_front(int i);
    return (i == 0) ? exp0_q[0] : exp1_q[0];
  endfunction

  task automatic q_push(int i, logic [23:0] v);
    if (i == 0) exp0_q.push_back(v);
    else        exp1_q.push_back(v);
  endtask

  task automatic q_drop(int i);
    if (i == 0) void'(exp0_q.pop_front());
    else        void'(exp1_q.pop_front());
  endtask

  task automatic chk(string name, int i, logic [31:0] act, logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s u%0d: got %0h expected %0h (t=%0t)", name, i, act, want, $time);
    end
  endtask

  // Monitor: every cycle a response is presented, it must match the oldest prediction
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!reset && rd_valid[i]) begin
        if (q_size(i) == 0) begin
          chk("rd_valid_unexpected", i, {31'h0, rd_valid[i]}, 32'h0);
        end else begin
          chk("rd_data", i, {8'h0, rd_data[i]}, {8'h0, q_front(i)});
          if (rd_ready[i]) begin
            $display("resp u%0d data=%0h", i, rd_data[i]);
            q_drop(i);
          end
        end
      end
    end
  end

  task automatic chk_flags(int i);
    chk("count", i, cnt[i], 32'(msz[i]));
    chk("full", i, {31'h0, full[i]}, {31'h0, msz[i] == dep(i)});
    chk("empty", i, {31'h0, empty[i]}, {31'h0, msz[i] == 0});
    chk("err_ovf", i, {31'h0, err_ovf[i]}, {31'h0, m_ovf[i]});
    chk("err_unf", i, {31'h0, err_unf[i]}, {31'h0, m_unf[i]});
  endtask

  bit rnd_rdy = 1'b0;

  // Issue one operation; waits for op_ready, updates model, checks flags and latency
  task automatic issue(int i, bit push, bit pop, logic [23:0] d, bit clr);
    int w;
    bit set_o, set_u, resp;
    logic [23:0] dm;
    w = 0;
    while (!op_ready[i] && w < 60) begin
      if (rnd_rdy) rd_ready[i] = ($urandom_range(0, 2) != 0);
      @(posedge clk); #1;
      w++;
    end
    if (!op_ready[i]) chk("op_ready_timeout", i, {31'h0, op_ready[i]}, 32'h1);
    dm = d & msk(i);
    op_valid[i] = 1'b1; op_push[i] = push; op_pop[i] = pop;
    wr_data[i] = d; err_clr[i] = clr;
    set_o = 1'b0; set_u = 1'b0; resp = 1'b0;
    if (push && !pop) begin
      if (msz[i] == dep(i)) set_o = 1'b1;
      else begin mdl[i][msz[i]] = dm; msz[i]++; end
    end else if (pop) begin
      if (msz[i] == 0) set_u = 1'b1;
      else begin
        q_push(i, mdl[i][msz[i]-1]);
        resp = 1'b1;
        if (push) mdl[i][msz[i]-1] = dm;
        else      msz[i]--;
      end
    end
    m_ovf[i] = set_o | (m_ovf[i] & !clr);
    m_unf[i] = set_u | (m_unf[i] & !clr);
    $display("op u%0d push=%0d pop=%0d data=%0h clr=%0d -> size=%0d", i, push, pop, dm, clr, msz[i]);
    @(posedge clk); #1;
    op_valid[i] = 1'b0; op_push[i] = 1'b0; op_pop[i] = 1'b0; err_clr[i] = 1'b0;
    chk_flags(i);
    chk("rd_valid_after_accept", i, {31'h0, rd_valid[i]}, 32'h0);
    if (resp) begin
      @(posedge clk); #1;
      chk("rd_valid_latency", i, {31'h0, rd_valid[i]}, 32'h1);
    end
  endtask

  task automatic clr_err(int i);
    err_clr[i] = 1'b1;
    @(posedge clk); #1;
    err_clr[i] = 1'b0;
    m_ovf[i] = 1'b0; m_unf[i] = 1'b0;
    chk_flags(i);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      msz[i] = 0; m_ovf[i] = 1'b0; m_unf[i] = 1'b0;
    end
    exp0_q.delete();
    exp1_q.delete();
  endtask

  task automatic chk_reset_state(int i);
    chk("rst_op_ready", i, {31'h0, op_ready[i]}, 32'h1);
    chk("rst_rd_valid", i, {31'h0, rd_valid[i]}, 32'h0);
    chk("rst_rd_data", i, {8'h0, rd_data[i]}, 32'h0);
    chk_flags(i);
  endtask

  task automatic drain(int i);
    int w;
    w = 0;
    rd_ready[i] = 1'b1;
    while ((rd_valid[i] || q_size(i) != 0) && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    chk("drain_pending", i, 32'(q_size(i)), 32'h0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      op_valid[i] = 1'b0; op_push[i] = 1'b0; op_pop[i] = 1'b0;
      rd_ready[i] = 1'b1; err_clr[i] = 1'b0; wr_data[i] = '0;
    end
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state(0);
    chk_reset_state(1);
    reset = 1'b0;
    @(posedge clk); #1;

    // 1) fill to full, then overflow
    for (int k = 1; k <= 8; k++) issue(0, 1'b1, 1'b0, 24'(k), 1'b0);
    issue(0, 1'b1, 1'b0, 24'hABCDEF, 1'b0);

    // 2) pop everything back out, then underflow
    for (int k = 0; k < 8; k++) issue(0, 1'b0, 1'b1, 24'h0, 1'b0);
    drain(0);
    issue(0, 1'b0, 1'b1, 24'h0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("no_resp_on_unf", 0, {31'h0, rd_valid[0]}, 32'h0);

    // 3) replace returns the old top
    clr_err(0);
    issue(0, 1'b1, 1'b0, 24'h5, 1'b0);
    issue(0, 1'b1, 1'b0, 24'h9, 1'b0);
    issue(0, 1'b1, 1'b1, 24'h7, 1'b0);
    issue(0, 1'b0, 1'b1, 24'h0, 1'b0);
    issue(0, 1'b0, 1'b1, 24'h0, 1'b0);
    drain(0);

    // 4) backpressure on the response
    issue(0, 1'b1, 1'b0, 24'h123456, 1'b0);
    rd_ready[0] = 1'b0;
    issue(0, 1'b0, 1'b1, 24'h0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("bp_rd_valid", 0, {31'h0, rd_valid[0]}, 32'h1);
      chk("bp_op_ready", 0, {31'h0, op_ready[0]}, 32'h0);
    end
    rd_ready[0] = 1'b1;
    @(posedge clk); #1;
    chk("bp_op_ready_after", 0, {31'h0, op_ready[0]}, 32'h1);
    chk("bp_rd_valid_after", 0, {31'h0, rd_valid[0]}, 32'h0);
    chk("bp_rd_data_held", 0, {8'h0, rd_data[0]}, 32'h123456);

    // 5) asynchronous reset in the middle of a held response
    issue(0, 1'b1, 1'b0, 24'h55AA55, 1'b0);
    rd_ready[0] = 1'b0;
    issue(0, 1'b0, 1'b1, 24'h0, 1'b0);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk("async_rst_rd_valid", 0, {31'h0, rd_valid[0]}, 32'h0);
    chk("async_rst_count", 0, cnt[0], 32'h0);
    chk("async_rst_empty", 0, {31'h0, empty[0]}, 32'h1);
    @(negedge clk);
    reset = 1'b0;
    rd_ready[0] = 1'b1;
    @(posedge clk); #1;
    chk_reset_state(0);
    for (int k = 0; k < 8; k++) issue(0, 1'b1, 1'b0, 24'($urandom), 1'b0);
    issue(0, 1'b1, 1'b0, 24'h111111, 1'b1);
    clr_err(0);

    // 6) small instance boundaries, full/empty toggling
    issue(1, 1'b1, 1'b0, 24'hA1, 1'b0);
    issue(1, 1'b1, 1'b0, 24'hB2, 1'b0);
    issue(1, 1'b1, 1'b0, 24'hC3, 1'b0);
    issue(1, 1'b0, 1'b1, 24'h0, 1'b0);
    issue(1, 1'b0, 1'b1, 24'h0, 1'b0);
    issue(1, 1'b0, 1'b1, 24'h0, 1'b0);
    clr_err(1);
    for (int k = 0; k < 4; k++) begin
      issue(1, 1'b1, 1'b0, 24'($urandom), 1'b0);
      issue(1, 1'b0, 1'b1, 24'($urandom), 1'b0);
    end
    drain(1);

    // Randomized traffic on both instances with random response backpressure
    rnd_rdy = 1'b1;
    for (int k = 0; k < 300; k++) begin
      int i;
      int op;
      i  = (k % 3 == 0) ? 0 : 1;
      op = $urandom_range(0, 3);
      issue(i, op[1], op[0], 24'($urandom), ($urandom_range(0, 15) == 0));
    end
    rnd_rdy = 1'b0;
    drain(0);
    drain(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
